mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the data-cache memory bus. It answers the `mem_rdreq`/`mem_wrreq` burst requests issued by the data cache and returns read data with a `mem_valid` strobe after a fixed latency. An internal word-addressed RAM array provides the storage. It replaces the ad-hoc single-port RAM model in cache benches and serves as the on-chip main-memory stand-in during bring-up.

## Interface
- `DATABITS`, 32, word width
- `ADDRBITS`, 32, byte-address width of `mem_addr`
- `MEMADDRBITS`, 9, log2 of array depth in words; word index is `mem_addr[MEMADDRBITS+1:2]`
- `LATENCY`, 1, cycles from accepted read request to first `mem_valid`; legal range 1..15

- `clk`  in  1  clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_addr`  in  ADDRBITS  byte address of the first word of the burst; bits [1:0] are ignored
- `mem_in`  in  DATABITS  write data from the cache
- `mem_out`  out  DATABITS  read data to the cache
- `mem_valid`  out  1  `mem_out` carries a read beat
- `mem_burstlen`  in  16  number of words in the burst; 0 means the request is ignored
- `mem_rdreq`  in  1  read request; single-cycle pulse
- `mem_wrreq`  in  1  write request; held high for one cycle per word
- `mem_busy`  out  1  a burst is in progress; new requests are dropped

## Operation
- **States:**
  - IDLE
  - RWAIT: latency countdown
  - RBURST: returning beats
  - WBURST: accepting beats
- **IDLE**, request sampled at an edge with `mem_burstlen != 0`:
  - Capture the word index into `ptr` and `mem_burstlen` into `remain`.
  - If both `mem_wrreq` and `mem_rdreq` are high, the write wins and the read is dropped.
- **Write, beat 0:**
  - `mem_in` is written to `array[ptr]` at the accepting edge.
  - If `remain==1`, stay in IDLE. Otherwise go to WBURST with `ptr+1` and `remain-1`.
- **WBURST:**
  - On each edge with `mem_wrreq=1`: write `mem_in` to `array[ptr]`, then `ptr++` and `remain--`. `mem_addr` is ignored.
  - After the last beat, return to IDLE.
  - An edge with `mem_wrreq=0` aborts the burst: go to IDLE. Words already written are kept.
- **Read:**
  - If `LATENCY==1`, go directly to RBURST. Otherwise go to RWAIT with a counter of `LATENCY-1`.
  - RWAIT decrements the counter each cycle. At 0 it goes to RBURST.
- **RBURST:**
  - Each cycle: `mem_out <= array[ptr]`, `mem_valid <= 1`, `ptr++`, `remain--`.
  - The edge producing the last beat returns to IDLE.
- **Pointer and requests:**
  - `ptr` wraps modulo 2^MEMADDRBITS. Address bits above `MEMADDRBITS+1` are ignored, so addresses alias.
  - `mem_rdreq` during WBURST/RWAIT/RBURST is dropped. There is no queueing.
  - `mem_wrreq` during RWAIT/RBURST is dropped.
- **Outputs:**
  - `mem_out` is 0 whenever `mem_valid=0`.
  - `mem_busy` = (state != IDLE).
- **Array contents:**
  - Not initialised and not cleared by reset.
  - The bench preloads them hierarchically when needed.

## Timing
- **Reset values:** `mem_out=0`, `mem_valid=0`, `mem_busy=0`, state IDLE, counters 0.
- **Reset mid-burst:** the burst is abandoned at once and no further beats are produced. Writes completed before reset persist.
- **Read latency:** request sampled at edge E0 → first `mem_valid` high in the cycle after edge E0+LATENCY-1. For `LATENCY=1`, valid is in the cycle directly after the request.
- **Read throughput:** burst beats are on consecutive cycles with no gaps; `mem_valid` is high for exactly `mem_burstlen` cycles.
- **`mem_busy`:**
  - Rises in the cycle after an accepted multi-beat write or any read.
  - Is already 0 during the cycle carrying the last read beat.
  - A request in that cycle is accepted, which gives back-to-back reads.
- **Single-beat write:** never raises `mem_busy`.
- **Read-after-write:** a write at edge E is visible to a read accepted at edge E+1 or later.

## Test plan
1. **Single writes and reads, `LATENCY=1`.**
   - Stimulus: write 0x0fff0001..0x0fff0004 to 0x80..0x8C as four single-beat writes, then rdreq 0x80 with burstlen 4.
   - Required: `mem_valid` high for 4 consecutive cycles starting the cycle after the request, with data 0x0fff0001..0x0fff0004. `mem_busy` is never high during the writes.
2. **Burst write with latency 3 read-back.**
   - Stimulus: `LATENCY=3`. Write burst of 12 to 0x80 with data 0x0fff0011+i. Then rdreq 0x80, burstlen 12.
   - Required: first valid in the third cycle after the request, 12 gapless beats matching the written data.
3. **Wrap-around.**
   - Stimulus: `MEMADDRBITS=9`. Burst write of 4 to 0x7F8 with data 0xA0..0xA3. Read 4 from 0x7F8.
   - Required: data comes back in order, and words 2–3 land at word indices 0–1; a read of 0x000 returns 0xA2.
4. **Dropped requests and arbitration.**
   - Stimulus: a rdreq during RBURST; simultaneous rdreq+wrreq in IDLE; burstlen 0.
   - Required:
     - The extra read produces no extra beats.
     - The write is performed and no read beats appear.
     - The burstlen-0 request leaves `mem_busy=0`.
5. **Aborted write.**
   - Stimulus: a write burst of 4 where `mem_wrreq` drops after 2 beats.
   - Required: `mem_busy` goes to 0, only the first 2 words are updated, and old data remains in words 3–4.
6. **Reset mid-read.**
   - Stimulus: assert `reset` on the second beat of an 8-beat read.
   - Required: the next cycle has `mem_valid=0`, `mem_out=0`, `mem_busy=0`, and a fresh read returns the correct data.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: data-cache <-> memory bus.
//   master : cache side, drives address/data/burst length and the two request strobes
//   slave  : memory side, returns read data with a valid strobe and reports busy
interface mem_responder_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32
);
  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic [DATABITS-1:0] mem_out;
  logic                mem_valid;
  logic [15:0]         mem_burstlen;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic                mem_busy;

  modport master (
    output mem_addr, mem_in, mem_burstlen, mem_rdreq, mem_wrreq,
    input  mem_out, mem_valid, mem_busy
  );

  modport slave (
    input  mem_addr, mem_in, mem_burstlen, mem_rdreq, mem_wrreq,
    output mem_out, mem_valid, mem_busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering cache burst reads/writes.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any burst, array contents kept
//   bus   : mem_responder_if.slave
//           in : mem_addr (byte addr of first word), mem_in, mem_burstlen (0 = ignore),
//                mem_rdreq (pulse), mem_wrreq (held one cycle per word)
//           out: mem_out (0 unless valid), mem_valid, mem_busy (burst in progress)
// Read beats appear starting in the cycle after edge E0+LATENCY-1, where E0 is
// the accepting edge, and run gapless. Requests arriving while busy are dropped.
module mem_responder #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int MEMADDRBITS = 9,
  parameter int LATENCY     = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << MEMADDRBITS;
  // RWAIT counts down to 0; the edge seen with the counter at 0 produces beat 0.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, RWAIT, RBURST, WBURST} state_e;

  state_e                 state_q, state_d;
  logic [MEMADDRBITS-1:0] ptr_q, ptr_d;
  logic [15:0]            remain_q, remain_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATABITS-1:0]    out_q, out_d;
  logic                   valid_q, valid_d;

  logic [DATABITS-1:0]    array_q [DEPTH];

  logic [MEMADDRBITS-1:0] req_idx;
  logic                   wr_en;
  logic [MEMADDRBITS-1:0] wr_idx;
  logic                   beat;
  logic [MEMADDRBITS-1:0] beat_idx;
  logic [15:0]            beat_left;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[ADDRBITS-1:MEMADDRBITS+2], bus.mem_addr[1:0]};

  assign req_idx = bus.mem_addr[MEMADDRBITS+1:2];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    cnt_d     = cnt_q;
    out_d     = '0;
    valid_d   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = ptr_q;
    beat      = 1'b0;
    beat_idx  = ptr_q;
    beat_left = remain_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_burstlen != 16'd0) begin
          if (bus.mem_wrreq) begin
            // Write beats over a simultaneous read; the read is dropped.
            wr_en    = 1'b1;
            wr_idx   = req_idx;
            ptr_d    = req_idx + 1'b1;
            remain_d = bus.mem_burstlen - 16'd1;
            if (bus.mem_burstlen != 16'd1) state_d = WBURST;
          end else if (bus.mem_rdreq) begin
            ptr_d    = req_idx;
            remain_d = bus.mem_burstlen;
            if (LATENCY == 1) begin
              // Zero wait: the accepting edge already launches beat 0.
              beat      = 1'b1;
              beat_idx  = req_idx;
              beat_left = bus.mem_burstlen;
            end else begin
              state_d = RWAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      RWAIT: begin
        if (cnt_q == 4'd0) beat = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      RBURST: beat = 1'b1;
      WBURST: begin
        if (bus.mem_wrreq) begin
          wr_en    = 1'b1;
          ptr_d    = ptr_q + 1'b1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = IDLE;
        end else begin
          state_d = IDLE;  // abort; words already written stay
        end
      end
      default: state_d = IDLE;
    endcase

    // The edge that launches the last beat returns to IDLE, so busy is
    // already low while that beat is on the bus (back-to-back reads).
    if (beat) begin
      out_d    = array_q[beat_idx];
      valid_d  = 1'b1;
      ptr_d    = beat_idx + 1'b1;
      remain_d = beat_left - 16'd1;
      state_d  = (beat_left == 16'd1) ? IDLE : RBURST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is never cleared; reset only blocks a write on its own edge.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) array_q[wr_idx] <= bus.mem_in;
  end

  assign bus.mem_out   = out_q;
  assign bus.mem_valid = valid_q;
  assign bus.mem_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (LATENCY 1 and 3) share one stimulus stream.
// A transaction-level model predicts, per responder, the memory contents, the
// cycle and data of every read beat (pushed into a queue when the request is
// issued) and the busy level; a monitor pops and compares every cycle.
module tb_mem_responder;
  localparam int DB = 32, AB = 32, MAB = 9, DEPTH = 1 << MAB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.DATABITS(DB), .ADDRBITS(AB)) bus0 ();
  mem_responder_if #(.DATABITS(DB), .ADDRBITS(AB)) bus1 ();

  assign bus1.mem_addr     = bus0.mem_addr;
  assign bus1.mem_in       = bus0.mem_in;
  assign bus1.mem_burstlen = bus0.mem_burstlen;
  assign bus1.mem_rdreq    = bus0.mem_rdreq;
  assign bus1.mem_wrreq    = bus0.mem_wrreq;

  mem_responder #(.DATABITS(DB), .ADDRBITS(AB), .MEMADDRBITS(MAB), .LATENCY(1))
    u_dut_l1 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DATABITS(DB), .ADDRBITS(AB), .MEMADDRBITS(MAB), .LATENCY(3))
    u_dut_l3 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } beat_t;

  beat_t       q0[$];
  beat_t       q1[$];
  int          lat[2] = '{1, 3};
  logic [31:0] mdl_mem [2][DEPTH];
  bit          wr_act[2];
  int          wr_ptr[2];
  int          wr_left[2];
  int          rd_last[2] = '{-1, -1};   // edge producing the last beat of current read
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  task automatic push(int k, int c, logic [31:0] d);
    beat_t e;
    e.cyc  = c;
    e.data = d;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drop every predicted beat launched at edge t or later.
  task automatic flush(int k, int t);
    if (k == 0) while (q0.size() > 0 && q0[q0.size()-1].cyc >= t) void'(q0.pop_back());
    else        while (q1.size() > 0 && q1[q1.size()-1].cyc >= t) void'(q1.pop_back());
  endtask

  // Effect of the current inputs at edge t on each responder's model.
  task automatic model_edge(int t);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        wr_act[k]  = 1'b0;
        rd_last[k] = -1;
        flush(k, t);
      end else if (wr_act[k]) begin
        if (bus0.mem_wrreq) begin
          mdl_mem[k][wr_ptr[k]] = bus0.mem_in;
          wr_ptr[k]  = (wr_ptr[k] + 1) % DEPTH;
          wr_left[k] = wr_left[k] - 1;
          if (wr_left[k] == 0) wr_act[k] = 1'b0;
        end else begin
          wr_act[k] = 1'b0;
        end
      end else if (t > rd_last[k] && bus0.mem_burstlen != 16'd0) begin
        int idx;
        int n;
        idx = int'(bus0.mem_addr[MAB+1:2]);
        n   = int'(bus0.mem_burstlen);
        if (bus0.mem_wrreq) begin
          mdl_mem[k][idx] = bus0.mem_in;
          if (n > 1) begin
            wr_act[k]  = 1'b1;
            wr_ptr[k]  = (idx + 1) % DEPTH;
            wr_left[k] = n - 1;
          end
        end else if (bus0.mem_rdreq) begin
          for (int i = 0; i < n; i++) push(k, t + lat[k] - 1 + i, mdl_mem[k][(idx + i) % DEPTH]);
          rd_last[k] = t + lat[k] + n - 2;
        end
      end
    end
  endtask

  task automatic mon(int k, logic v, logic [31:0] d, logic b);
    beat_t e;
    bit    have;
    have = 1'b0;
    if (k == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin have = 1'b1; e = q0.pop_front(); end
    if (k == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin have = 1'b1; e = q1.pop_front(); end
    if (have) begin
      check($sformatf("L%0d_beat_valid", lat[k]), 64'(v), 64'd1);
      check($sformatf("L%0d_beat_data", lat[k]), 64'(d), 64'(e.data));
    end else begin
      check($sformatf("L%0d_idle_valid", lat[k]), 64'(v), 64'd0);
      check($sformatf("L%0d_idle_out", lat[k]), 64'(d), 64'd0);
    end
    check($sformatf("L%0d_busy", lat[k]), 64'(b), 64'(wr_act[k] || (cyc < rd_last[k])));
  endtask

  // Monitor: after each edge, compare both responders against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        mon(0, bus0.mem_valid, bus0.mem_out, bus0.mem_busy);
        mon(1, bus1.mem_valid, bus1.mem_out, bus1.mem_busy);
      end
    end
  end

  // One clock: model the coming edge, then let it happen.
  task automatic step();
    @(negedge clk);
    #1;
    model_edge(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(bit rd, bit wr, logic [31:0] addr, int len, logic [31:0] din);
    bus0.mem_rdreq    = rd;
    bus0.mem_wrreq    = wr;
    bus0.mem_addr     = addr;
    bus0.mem_burstlen = 16'(len);
    bus0.mem_in       = din;
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 0, 32'h0);
  endtask

  task automatic rd(logic [31:0] addr, int len);
    drive(1'b1, 1'b0, addr, len, 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);

    // Known contents everywhere: one 512-word burst from word 0.
    drive(1'b0, 1'b1, 32'h0, DEPTH, $urandom);
    for (int i = 1; i < DEPTH; i++) drive(1'b0, 1'b1, $urandom, DEPTH, $urandom);
    idle(2);

    // Single writes then a 4-beat read.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h80 + 32'(4*i), 1, 32'h0fff0001 + 32'(i));
    rd(32'h80, 4);
    idle(8);

    // 12-beat burst write, read back.
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 32'h80, 12, 32'h0fff0011 + 32'(i));
    rd(32'h80, 12);
    idle(16);

    // Wrap-around past the last word; high address bits alias.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h7F8, 4, 32'hA0 + 32'(i));
    idle(1);
    rd(32'h7F8, 4);
    idle(8);
    rd(32'h000, 1);
    idle(5);
    rd(32'hFFFF_F800, 2);
    idle(6);

    // Dropped read during a burst, write-wins arbitration, burstlen 0.
    rd(32'h100, 8);
    idle(2);
    rd(32'h200, 4);
    idle(12);
    drive(1'b1, 1'b1, 32'h300, 1, 32'hDEAD0001);
    idle(3);
    rd(32'h300, 1);
    idle(5);
    drive(1'b1, 1'b0, 32'h40, 0, 32'h0);
    drive(1'b0, 1'b1, 32'h40, 0, 32'hBAD);
    idle(3);
    rd(32'h40, 1);
    idle(5);

    // Back-to-back reads: new request in the cycle of the last beat.
    rd(32'h10, 3);
    idle(2);
    rd(32'h20, 2);
    idle(8);

    // Aborted write after 2 of 4 beats.
    drive(1'b0, 1'b1, 32'h180, 4, 32'hC0);
    drive(1'b0, 1'b1, 32'h180, 4, 32'hC1);
    idle(2);
    rd(32'h180, 4);
    idle(8);

    // Reset on the second beat of an 8-beat read, then a fresh read.
    rd(32'h80, 8);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    rd(32'h80, 8);
    idle(14);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rd($urandom, $urandom_range(0, 8));
        3, 4, 5: begin
          n = $urandom_range(1, 6);
          drive(1'($urandom_range(0, 1)), 1'b1, $urandom, n, $urandom);
          for (int i = 1; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) break;
            drive(1'($urandom_range(0, 1)), 1'b1, $urandom, n, $urandom);
          end
        end
        6: begin
          reset = ($urandom_range(0, 4) == 0);
          idle(1);
          reset = 1'b0;
        end
        default: idle($urandom_range(1, 4));
      endcase
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
